// File: rtl/qos_vc_scheduler_if.sv
// Scheduler-side bundle between the per-VC TX queues, the datapath and the link mux select.
// master drives policy/requests/done; slave (the scheduler) returns the registered grant.
interface qos_vc_scheduler_if #(
    parameter int NUM_CH   = 4,
    parameter int WEIGHT_W = 8
);
    logic                         enb;
    logic [1:0]                   sel;
    logic [NUM_CH*WEIGHT_W-1:0]   weight_table;
    logic [NUM_CH-1:0]            req;
    logic                         done;
    logic [NUM_CH-1:0]            grant;
    logic                         grant_valid;
    logic [$clog2(NUM_CH)-1:0]    grant_id;
    logic                         busy;

    modport master (
        output enb, sel, weight_table, req, done,
        input  grant, grant_valid, grant_id, busy
    );

    modport slave (
        input  enb, sel, weight_table, req, done,
        output grant, grant_valid, grant_id, busy
    );
endinterface

// File: rtl/qos_vc_scheduler.sv
// Packet-level VC scheduler (RR / disabled / WRR / strict priority); grant registered 1 cycle after req sample.
// Grant held until done; no new grant while BUSY, on a policy-change cycle, or when enb is low.
module qos_vc_scheduler #(
    parameter int NUM_CH   = 4,
    parameter int WEIGHT_W = 8
) (
    input logic              clk,
    input logic              reset,
    qos_vc_scheduler_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_CH);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t                r_state;
    logic [NUM_CH-1:0]     r_grant;
    logic                  r_grant_valid;
    logic [IDX_W-1:0]      r_grant_id;
    logic                  r_busy;
    logic [IDX_W-1:0]      r_ptr;
    logic [WEIGHT_W-1:0]   r_cnt;
    logic [1:0]            r_sel_q;

    logic [NUM_CH-1:0]     w_req;
    logic [WEIGHT_W-1:0]   w_wt [NUM_CH];
    logic [NUM_CH-1:0]     w_elig;
    logic                  w_rr_vld;
    logic [IDX_W-1:0]      w_rr_win;
    logic                  w_sp_vld;
    logic [IDX_W-1:0]      w_sp_win;
    logic                  w_wrr_vld;
    logic [IDX_W-1:0]      w_wrr_win;
    logic                  w_wrr_stay;
    logic                  w_win_vld;
    logic [IDX_W-1:0]      w_win;
    logic [IDX_W-1:0]      w_nxt_ptr;
    logic [WEIGHT_W-1:0]   w_nxt_cnt;
    logic                  w_sel_chg;

    assign w_req     = bus.req;
    assign w_sel_chg = (bus.sel != r_sel_q);

    always_comb begin
        logic [IDX_W-1:0] idx;
        idx        = '0;
        w_rr_vld   = 1'b0;
        w_rr_win   = '0;
        w_sp_vld   = 1'b0;
        w_sp_win   = '0;
        w_wrr_vld  = 1'b0;
        w_wrr_win  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_wt[c]   = bus.weight_table[c*WEIGHT_W +: WEIGHT_W];
            w_elig[c] = w_req[c] && (w_wt[c] != '0);
        end
        // Scan from the far end so the nearest hit is the one left standing.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = r_ptr + IDX_W'(k);
            if (w_req[idx]) begin
                w_rr_vld = 1'b1;
                w_rr_win = idx;
            end
            if (w_req[k]) begin
                w_sp_vld = 1'b1;
                w_sp_win = IDX_W'(k);
            end
        end
        // WRR hand-off starts at ptr+1 and wraps back to ptr itself last.
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = r_ptr + IDX_W'(k);
            if (w_elig[idx]) begin
                w_wrr_vld = 1'b1;
                w_wrr_win = idx;
            end
        end
        w_wrr_stay = w_elig[r_ptr] && (r_cnt < w_wt[r_ptr]);
    end

    always_comb begin
        w_win_vld = 1'b0;
        w_win     = '0;
        w_nxt_ptr = r_ptr;
        w_nxt_cnt = r_cnt;
        case (bus.sel)
            2'b00: begin
                if (w_rr_vld) begin
                    w_win_vld = 1'b1;
                    w_win     = w_rr_win;
                    w_nxt_ptr = w_rr_win + IDX_W'(1);
                end
            end
            2'b10: begin
                if (w_wrr_stay) begin
                    w_win_vld = 1'b1;
                    w_win     = r_ptr;
                    w_nxt_cnt = r_cnt + WEIGHT_W'(1);
                end else if (w_wrr_vld) begin
                    w_win_vld = 1'b1;
                    w_win     = w_wrr_win;
                    w_nxt_ptr = w_wrr_win;
                    w_nxt_cnt = WEIGHT_W'(1);
                end
            end
            2'b11: begin
                if (w_sp_vld) begin
                    w_win_vld = 1'b1;
                    w_win     = w_sp_win;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_busy        <= 1'b0;
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_sel_q       <= 2'b00;
        end else begin
            r_sel_q <= bus.sel;
            if (w_sel_chg) begin
                r_ptr <= '0;
                r_cnt <= '0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (!w_sel_chg && bus.enb && w_win_vld) begin
                        r_state       <= ST_BUSY;
                        r_grant       <= {{(NUM_CH-1){1'b0}}, 1'b1} << w_win;
                        r_grant_id    <= w_win;
                        r_grant_valid <= 1'b1;
                        r_busy        <= 1'b1;
                        r_ptr         <= w_nxt_ptr;
                        r_cnt         <= w_nxt_cnt;
                    end
                end
                ST_BUSY: begin
                    if (bus.done) begin
                        r_state       <= ST_IDLE;
                        r_grant       <= '0;
                        r_grant_id    <= '0;
                        r_grant_valid <= 1'b0;
                        r_busy        <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_valid = r_grant_valid;
    assign bus.grant_id    = r_grant_id;
    assign bus.busy        = r_busy;
endmodule

// File: doc/qos_vc_scheduler.md
Name: qos_vc_scheduler

Overview:
- Packet-level scheduler that shares the egress link between four PCIe virtual-channel (VC) request queues.
- Selects one VC per packet under a runtime-selected policy: round robin, disabled, weighted round robin (WRR) or strict priority.
- Holds each grant until the datapath signals packet completion.
- Sits between the per-VC TX queues and the link-layer mux; drives the mux select.

Parameters:
- NUM_CH, 4, number of VCs; fixed at 4 in this revision.
- WEIGHT_W, 8, width of one per-VC weight field.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enb  input  1  scheduler enable; low blocks new grants.
- sel  input  2  policy: 00 RR, 01 disabled, 10 WRR, 11 strict priority.
- weight_table  input  NUM_CH*WEIGHT_W  packets per WRR turn; VC i weight = bits [i*WEIGHT_W +: WEIGHT_W].
- req  input  NUM_CH  per-VC "packet pending", level.
- done  input  1  single-cycle pulse: granted packet fully transferred.
- grant  output  NUM_CH  one-hot grant, held for the whole packet.
- grant_valid  output  1  high while any grant is active.
- grant_id  output  2  binary index of the granted VC (0 when none).
- busy  output  1  FSM in BUSY.

Behaviour:
- Reset values: grant=0, grant_valid=0, grant_id=0, busy=0, FSM=IDLE, ptr=0, cnt=0, sel_q=00.
- FSM states:
  - IDLE -> BUSY when enb=1, sel!=01 and a winner exists. grant, grant_id and grant_valid are registered and appear the cycle after the req sample (1-cycle latency).
  - BUSY -> IDLE on the done cycle. Outputs clear the next cycle, so consecutive grants are at least 1 idle cycle apart.
- BUSY holds: grant stays constant in BUSY regardless of req, enb or sel changes. Only done or reset ends it.
- done while IDLE: ignored.
- RR (sel=00):
  - Winner = first c with req[c]=1, searched cyclically starting at ptr.
  - On grant, ptr <= winner+1 (mod 4).
- WRR (sel=10):
  - Eligible VC: req[c]=1 and weight[c]!=0. A weight-0 VC is never granted in WRR.
  - cnt counts grants given to ptr in the current turn.
  - If ptr is eligible and cnt < weight[ptr]: winner=ptr, cnt<=cnt+1.
  - Otherwise: winner = first eligible VC searched cyclically from ptr+1. The search may wrap back to ptr if it is the only eligible VC. Then ptr<=winner, cnt<=1.
  - cnt is WEIGHT_W bits and never exceeds 2^WEIGHT_W-1.
- Strict priority (sel=11):
  - Lowest-index requesting VC wins.
  - ptr and cnt are unchanged.
- Disabled (sel=01): no new grants; an in-flight grant completes normally.
- Policy change:
  - sel_q registers sel every cycle.
  - When sel!=sel_q, ptr<=0 and cnt<=0 in that cycle.
  - No grant is issued in that cycle.
  - An in-flight BUSY grant is not affected.
- No requests: stay IDLE, all outputs 0.
- Reset mid-packet: grant drops the next cycle; all state returns to reset values.
- done together with a new req in the same cycle: the request is considered only from the next IDLE cycle.

Test Plan:
1. RR, req=1111, done pulsed 2 cycles after each grant -> grant_id sequence 0,1,2,3,0; one idle cycle between grants.
2. WRR, weights VC0..3 = 2,1,0,3, req=1111 -> grant_id sequence 0,0,1,3,3,3,0,0; VC2 never granted.
3. WRR with only req[1]=1, weight1=1 -> VC1 re-granted every packet, cnt reloads to 1 each time.
4. Strict priority, req=1010 -> grant=0010 repeatedly; clear req[1] -> grant=1000.
5. Switch sel 00->01 while BUSY on VC2 -> grant=0100 held until done, then no further grants; switch back to 00 -> next grant searched from VC0.
6. reset asserted in BUSY -> next cycle grant=0, grant_valid=0, busy=0; with enb=0 and req=1111 -> no grant ever issued.
